zigzag_quant: RTL and testbench

Downstream stage of the 2-D DCT. Captures 64 coefficients per 8x8 block in natural (row-major) order into a ping-pong buffer. Re-emits them in JPEG zigzag order, quantized by a runtime-loadable reciprocal table, over a valid/ready stream for the entropy coder. The DCT side has no backpressure, so this block absorbs the rate mismatch and flags overflow.

---
 rtl/dct_pkg.sv | 30 +++
 rtl/zq_pingpong_ram.sv | 43 ++++
 rtl/zigzag_quant.sv | 214 +++++++++++++++++++++
 tb/tb_zigzag_quant.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT back-end stages:
// default widths, the zigzag-to-natural index map and the read-side state enum.
package dct_pkg;

    localparam int IN_WIDTH_DEF    = 16;
    localparam int OUT_WIDTH_DEF   = 12;
    localparam int RECIP_WIDTH_DEF = 17;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bank_state_e;

    // ZZ[k] is the natural (row-major) address of zigzag position k.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_addr(input logic [5:0] k);
        return ZZ[k];
    endfunction

endpackage

// File: rtl/zq_pingpong_ram.sv
// Two 64-entry coefficient banks. One bank is written while the other is
// read; bank_sel names the write bank and flips on every swap.
module zq_pingpong_ram #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             swap,
    input  logic             wr_en,
    input  logic [5:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [5:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2][64];
    logic             bank_sel;

    // Bank select: toggles on swap so the freshly filled bank becomes the read bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel <= 1'b0;
        end else if (swap) begin
            bank_sel <= ~bank_sel;
        end
    end

    // Write port into the current write bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bank_sel][wr_addr] <= wr_data;
        end
    end

    // Synchronous read port from the current read bank; holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[~bank_sel][rd_addr];
        end
    end

endmodule

// File: rtl/zigzag_quant.sv
// Zigzag reorder and quantizer between the 2-D DCT and the entropy coder.
// Coefficients arrive in natural order with no backpressure, are buffered in a
// ping-pong RAM and leave in zigzag order over a valid/ready stream.
// Build option ZIGZAG_QUANT_EN: when defined, each output is multiplied by a
// runtime-loadable reciprocal and rounded; otherwise the value is only saturated.
module zigzag_quant
    import dct_pkg::*;
#(
    parameter int IN_WIDTH    = IN_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int RECIP_WIDTH = RECIP_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   qt_wr_en,
    input  logic [5:0]             qt_addr,
    input  logic [RECIP_WIDTH-1:0] qt_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [5:0]             out_index,
    output logic                   out_last,
    output logic                   overflow
);

    // Output stream: a word moves when out_valid && out_ready. While out_valid is
    // high and out_ready low, out_data/out_index/out_last hold. The whole read
    // pipeline advances only when the output register is empty or being taken.

    localparam logic [OUT_WIDTH-1:0] Q_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] Q_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [5:0]                 wr_cnt;
    logic                       pending;
    logic                       wr_en;
    logic                       block_done;
    logic                       full_now;
    bank_state_e                state, state_nxt;
    logic [5:0]                 rd_k, rd_k_nxt;
    logic                       advance;
    logic                       issue;
    logic                       read_free;
    logic                       swap;
    logic signed [IN_WIDTH-1:0] rd_data;
    logic                       s1_valid;
    logic [5:0]                 s1_k;
    logic [OUT_WIDTH-1:0]       q_val;

    assign advance    = !out_valid || out_ready;
    assign wr_en      = in_valid && !pending;
    assign block_done = wr_en && (wr_cnt == 6'd63);
    assign full_now   = pending || block_done;

    zq_pingpong_ram #(.WIDTH(IN_WIDTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .swap    (swap),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_en   (issue),
        .rd_addr (zz_addr(rd_k)),
        .rd_data (rd_data)
    );

    // Write side: count accepted words; a full bank that cannot swap yet stays
    // pending and every word offered meanwhile is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= 6'd0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 6'd1;
            end
            if (in_valid && pending) begin
                overflow <= 1'b1;
            end
            pending <= full_now && !swap;
        end
    end

    // Read-side state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rd_k  <= 6'd0;
        end else begin
            state <= state_nxt;
            rd_k  <= rd_k_nxt;
        end
    end

    // Read-side next state: issue one zigzag read per advance; the side is free
    // again once k=63 has been issued, so a waiting bank swaps in with no bubble.
    always_comb begin
        state_nxt = state;
        rd_k_nxt  = rd_k;
        issue     = 1'b0;
        read_free = (state == IDLE);
        swap      = 1'b0;
        if (state == RUN && advance) begin
            issue    = 1'b1;
            rd_k_nxt = rd_k + 6'd1;
            if (rd_k == 6'd63) begin
                read_free = 1'b1;
                state_nxt = IDLE;
            end
        end
        if (full_now && read_free) begin
            swap      = 1'b1;
            state_nxt = RUN;
            rd_k_nxt  = 6'd0;
        end
    end

    // Stage 1 bookkeeping travelling alongside the RAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_k     <= 6'd0;
        end else if (advance) begin
            s1_valid <= issue;
            if (issue) begin
                s1_k <= rd_k;
            end
        end
    end

`ifdef ZIGZAG_QUANT_EN
    localparam int               PW      = IN_WIDTH + RECIP_WIDTH + 1;
    localparam logic [PW-1:0]    HALF    = PW'(1) << 15;
    localparam logic [PW-1:0]    POS_LIM = PW'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic [PW-1:0]    NEG_LIM = PW'(1 << (OUT_WIDTH-1));

    logic [RECIP_WIDTH-1:0] qtab [64];
    logic [RECIP_WIDTH-1:0] s1_recip;
    logic signed [PW-1:0]   prod;
    logic [PW-1:0]          mag;
    logic [PW-1:0]          rnd;
    logic [OUT_WIDTH-1:0]   neg_q;

    // Reciprocal table, identity (2^16) after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                qtab[i] <= RECIP_WIDTH'(1 << 16);
            end
        end else if (qt_wr_en) begin
            qtab[qt_addr] <= qt_data;
        end
    end

    // Table lookup in the same stage as the RAM read; a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_recip <= '0;
        end else if (advance && issue) begin
            s1_recip <= qtab[rd_k];
        end
    end

    // Multiply, round half away from zero, saturate.
    always_comb begin
        prod  = PW'(rd_data) * $signed(PW'({1'b0, s1_recip}));
        mag   = prod[PW-1] ? PW'(-prod) : PW'(prod);
        rnd   = (mag + HALF) >> 16;
        neg_q = OUT_WIDTH'(0) - rnd[OUT_WIDTH-1:0];
        if (prod[PW-1]) begin
            q_val = (rnd > NEG_LIM) ? Q_MIN : neg_q;
        end else begin
            q_val = (rnd > POS_LIM) ? Q_MAX : rnd[OUT_WIDTH-1:0];
        end
    end
`else
    localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_LO = ~SAT_HI;

    logic unused_qt;
    assign unused_qt = ^{qt_wr_en, qt_addr, qt_data};

    // Pass-through with saturation only.
    always_comb begin
        if (rd_data > SAT_HI) begin
            q_val = Q_MAX;
        end else if (rd_data < SAT_LO) begin
            q_val = Q_MIN;
        end else begin
            q_val = rd_data[OUT_WIDTH-1:0];
        end
    end
`endif

    // Output register: loads when empty or being accepted, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 6'd0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= q_val;
                out_index <= s1_k;
                out_last  <= (s1_k == 6'd63);
            end
        end
    end

endmodule

// File: tb/tb_zigzag_quant.sv
// Bench for zigzag_quant: randomized blocks against a reference model built
// from the zigzag walk and plain rounded-division arithmetic.
module tb_zigzag_quant;

    localparam int IW = 16;
    localparam int OW = 12;
    localparam int RW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          qt_wr_en;
    logic [5:0]    qt_addr;
    logic [RW-1:0] qt_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [5:0]    out_index;
    logic          out_last;
    logic          overflow;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            ready_mode = 1;
    int            zz [64];
    int            m_recip [64];
    logic [18:0]   exp_q [$];
    int            run_n = 0;
    int            run_first = 0;
    int            run_last = 0;
    int            lat;

    zigzag_quant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .qt_wr_en  (qt_wr_en),
        .qt_addr   (qt_addr),
        .qt_data   (qt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model
    function automatic void build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[k] = 8 * r + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz[k] = 8 * r + (s - r);
                    k++;
                end
            end
        end
    endfunction

    function automatic logic [OW-1:0] model_q(input int coef, input int recip);
        longint p, m, r;
        p = longint'(coef) * longint'(recip);
        m = (p < 0) ? -p : p;
        r = (m + 32768) / 65536;
        if (p < 0) r = -r;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return r[OW-1:0];
    endfunction

    function automatic int cur_recip(input int k);
`ifdef ZIGZAG_QUANT_EN
        return m_recip[k];
`else
        return 65536 + 0 * k;
`endif
    endfunction

    function automatic int gen_coef(input int mode, input int n);
        case (mode)
            0: return n;
            1: return (n == 5) ? 8 : -100;
            2: begin
                case (n % 4)
                    0: return 3000;
                    1: return -3000;
                    2: return int'($urandom_range(0, 65535)) - 32768;
                    default: return int'($urandom_range(0, 200)) - 100;
                endcase
            end
            default: begin
                if (n % 2 == 1) return int'($urandom_range(0, 65535)) - 32768;
                return int'($urandom_range(0, 3000)) - 1500;
            end
        endcase
    endfunction

    // Driver tasks
    task automatic drive_blocks(input int nblk, input int mode, input int keep);
        int coef [64];
        for (int b = 0; b < nblk; b++) begin
            for (int n = 0; n < 64; n++) coef[n] = gen_coef(mode, n);
            if (b < keep) begin
                for (int k = 0; k < 64; k++) begin
                    exp_q.push_back({(k == 63), 6'(k), model_q(coef[zz[k]], cur_recip(k))});
                end
            end
            for (int n = 0; n < 64; n++) begin
                @(posedge clk); #1;
                in_valid = 1'b1;
                in_data  = IW'(coef[n]);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_table(input int mode);
        for (int k = 0; k < 64; k++) begin
            int q;
            int v;
            case (mode)
                0: v = 65536;
                1: v = 4096;
                default: begin
                    q = int'($urandom_range(1, 64));
                    v = (65536 + q / 2) / q;
                end
            endcase
            m_recip[k] = v;
            @(posedge clk); #1;
            qt_wr_en = 1'b1;
            qt_addr  = 6'(k);
            qt_data  = RW'(v);
        end
        @(posedge clk); #1;
        qt_wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_idle"}, out_valid, 1'b0);
    endtask

    // Consumer ready
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: compare transfers in order, check hold while stalled
    initial begin
        logic [18:0] w;
        logic [18:0] prev_word;
        logic        prev_stall;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_word", {out_last, out_index, out_data}, prev_word);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("data", out_data, w[11:0]);
                        check("index", out_index, w[17:12]);
                        check("last", out_last, w[18]);
                    end
                    if (run_n == 0) run_first = cyc;
                    run_last = cyc;
                    run_n++;
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_last, out_index, out_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Test sequence
    initial begin
        build_zz();
        for (int k = 0; k < 64; k++) m_recip[k] = 65536;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        qt_wr_en = 1'b0;
        qt_addr  = '0;
        qt_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Identity ramp: zigzag order and first-output latency
        drive_blocks(1, 0, 1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("first_latency", lat, 2);
        drain("ramp");

        // Q=16 table: -100 -> -6, 8 -> 1
        load_table(1);
        drive_blocks(1, 1, 1);
        drain("q16");

        // Identity table saturation
        load_table(0);
        drive_blocks(1, 2, 1);
        drain("sat");

        // Two blocks back-to-back, no bubble
        run_n = 0;
        drive_blocks(2, 3, 2);
        drain("b2b");
        check("b2b_count", run_n, 128);
        check("b2b_span", run_last - run_first, 127);
        check("b2b_overflow", overflow, 1'b0);

        // Three blocks with consumer stalled: third dropped
        ready_mode = 0;
        @(posedge clk);
        drive_blocks(3, 3, 2);
        check("stall_overflow", overflow, 1'b1);
        check("stall_valid", out_valid, 1'b1);
        check("stall_index", out_index, 0);
        repeat (10) @(posedge clk);
        ready_mode = 1;
        drain("drop");
        check("sticky_overflow", overflow, 1'b1);

        // Reset in the middle of a block discards it
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = IW'($urandom_range(0, 65535));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_valid", out_valid, 1'b0);
        for (int k = 0; k < 64; k++) m_recip[k] = 65536;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_blocks(1, 3, 1);
        drain("post_rst");

        // Random table with random backpressure
        load_table(2);
        ready_mode = 2;
        drive_blocks(2, 3, 2);
        drain("rand");
        check("rand_overflow", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
